// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: FIFO of retired-instruction records drained over a valid/ready trace port.
// Optional COMMIT_TRACE_CHECKSUM_EN adds a rolling checksum of accepted GPR writes.
module commit_trace_buffer #(
    parameter int DEPTH = 16,
    parameter int AFULL_THRESH = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        commit_valid_i,
    input  logic [31:0] commit_pc_i,
    input  logic [31:0] commit_instr_i,
    input  logic        commit_wreg_i,
    input  logic [4:0]  commit_waddr_i,
    input  logic [31:0] commit_wdata_i,
    input  logic        flush_i,
    input  logic        trace_ready_i,
    output logic        trace_valid_o,
    output logic [31:0] trace_pc_o,
    output logic [31:0] trace_instr_o,
    output logic        trace_wreg_o,
    output logic [4:0]  trace_waddr_o,
    output logic [31:0] trace_wdata_o,
    output logic [15:0] trace_seq_o,
    output logic        almost_full_o,
    output logic        overflow_o,
    output logic [15:0] drop_cnt_o,
    output logic [31:0] commit_cnt_o
`ifdef COMMIT_TRACE_CHECKSUM_EN
    ,
    output logic [31:0] checksum_o
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
    localparam logic [PW:0] THRESH = (PW+1)'(AFULL_THRESH);

    logic [31:0] mem_pc [DEPTH];
    logic [31:0] mem_instr [DEPTH];
    logic        mem_wreg [DEPTH];
    logic [4:0]  mem_waddr [DEPTH];
    logic [31:0] mem_wdata [DEPTH];
    logic [15:0] mem_seq [DEPTH];

    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [PW:0]   count, count_nx;
    logic [15:0]   seq;
    logic          pop, push, drop, wreg_f;

    // Flush suppresses both sides so nothing moves in the flush cycle.
    always_comb begin
        wreg_f   = commit_wreg_i & (commit_waddr_i != 5'd0);
        pop      = trace_valid_o & trace_ready_i & ~flush_i;
        push     = commit_valid_i & ~flush_i & ((count != FULL) | pop);
        drop     = commit_valid_i & ~flush_i & (count == FULL) & ~pop;
        count_nx = count + (PW+1)'(push) - (PW+1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr]    <= commit_pc_i;
            mem_instr[wr_ptr] <= commit_instr_i;
            mem_wreg[wr_ptr]  <= wreg_f;
            mem_waddr[wr_ptr] <= commit_waddr_i;
            mem_wdata[wr_ptr] <= commit_wdata_i;
            mem_seq[wr_ptr]   <= seq;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            seq           <= '0;
            almost_full_o <= 1'b0;
            overflow_o    <= 1'b0;
            drop_cnt_o    <= '0;
            commit_cnt_o  <= '0;
        end else begin
            commit_cnt_o <= commit_cnt_o + 32'(commit_valid_i);
            if (flush_i) begin
                rd_ptr        <= '0;
                wr_ptr        <= '0;
                count         <= '0;
                almost_full_o <= 1'b0;
                overflow_o    <= 1'b0;
                drop_cnt_o    <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                    seq    <= seq + 16'd1;
                end
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                count         <= count_nx;
                almost_full_o <= count_nx >= THRESH;
                if (drop) begin
                    overflow_o <= 1'b1;
                    drop_cnt_o <= drop_cnt_o == 16'hFFFF ? drop_cnt_o : drop_cnt_o + 16'd1;
                end
            end
        end
    end

    // Head fields read zero while empty.
    always_comb begin
        trace_valid_o = count != '0;
        trace_pc_o    = trace_valid_o ? mem_pc[rd_ptr] : '0;
        trace_instr_o = trace_valid_o ? mem_instr[rd_ptr] : '0;
        trace_wreg_o  = trace_valid_o ? mem_wreg[rd_ptr] : 1'b0;
        trace_waddr_o = trace_valid_o ? mem_waddr[rd_ptr] : '0;
        trace_wdata_o = trace_valid_o ? mem_wdata[rd_ptr] : '0;
        trace_seq_o   = trace_valid_o ? mem_seq[rd_ptr] : '0;
    end

`ifdef COMMIT_TRACE_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst || flush_i)
            checksum_o <= '0;
        else if (push && wreg_f)
            checksum_o <= {checksum_o[30:0], checksum_o[31]} ^ commit_wdata_i ^ {27'b0, commit_waddr_i};
    end
`endif
endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
- Sits directly downstream of the CPU core's writeback stage.
- Consumes the per-cycle commit stream: commit PC, instruction word, valid flag, register-write enable, write address and write data.
- Buffers commits in a FIFO and presents them on a valid/ready trace port, so a difftest checker or a slow UART/trace sink can drain them without losing retirements.
- Also reports backpressure (almost-full), sticky overflow, drop statistics and retirement statistics.

Parameters:
- DEPTH, 16, FIFO entries; must be a power of 2, minimum 2.
- AFULL_THRESH, 12, occupancy at or above which almost_full_o asserts; must be 1..DEPTH.

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high
- commit_valid_i  input  1  one instruction retired this cycle
- commit_pc_i  input  32  PC of the retired instruction
- commit_instr_i  input  32  instruction word
- commit_wreg_i  input  1  retired instruction writes the GPR file
- commit_waddr_i  input  5  destination GPR
- commit_wdata_i  input  32  value written to the GPR
- flush_i  input  1  discard all buffered entries
- trace_ready_i  input  1  sink accepts the head entry
- trace_valid_o  output  1  head entry is valid
- trace_pc_o  output  32  head PC
- trace_instr_o  output  32  head instruction word
- trace_wreg_o  output  1  head write enable
- trace_waddr_o  output  5  head destination GPR
- trace_wdata_o  output  32  head write data
- trace_seq_o  output  16  sequence number of the head entry
- almost_full_o  output  1  occupancy >= AFULL_THRESH
- overflow_o  output  1  sticky: at least one commit was dropped
- drop_cnt_o  output  16  dropped commits, saturating
- commit_cnt_o  output  32  total commits observed, wrapping

Behaviour:
- Reset values (on any cycle rst=1):
  - FIFO empty; read/write pointers and count = 0.
  - trace_valid_o=0, almost_full_o=0, overflow_o=0, drop_cnt_o=0, commit_cnt_o=0.
  - Sequence counter = 0.
  - Head data outputs = 0 while empty.
  - Reset mid-operation discards every entry; there is no partial drain.
- Push:
  - A push is attempted when commit_valid_i=1.
  - Accepted when count<DEPTH, or when count==DEPTH and a pop happens in the same cycle.
  - An accepted entry is written at wr_ptr; wr_ptr advances modulo DEPTH.
  - The entry's sequence number is the current sequence counter, which then increments with 16-bit wrap (0xFFFF -> 0x0000).
- r0 filtering: if commit_wreg_i=1 and commit_waddr_i=0, the entry is stored with wreg=0. waddr and wdata are stored unchanged.
- Pop:
  - Occurs when trace_valid_o & trace_ready_i.
  - rd_ptr advances modulo DEPTH.
  - trace_ready_i while empty has no effect.
- Head outputs:
  - trace_valid_o = (count!=0).
  - trace_* fields reflect the entry at rd_ptr combinationally from storage.
  - Fields must stay stable while trace_valid_o=1 and trace_ready_i=0.
- Latency: a commit pushed into an empty FIFO in cycle N appears on trace_valid_o in cycle N+1. There is no bypass.
- Simultaneous push and pop: count is unchanged, and this holds when full.
- Drop: a push attempted while count==DEPTH and no pop is dropped.
  - drop_cnt_o increments, saturating at 0xFFFF.
  - overflow_o is set.
  - The sequence counter does NOT advance, so a gap in trace_seq_o is never produced by drops.
- commit_cnt_o increments on every cycle with commit_valid_i=1, whether accepted, dropped or flushed. It wraps at 2^32.
- almost_full_o is registered and reflects occupancy after the current cycle's update.
- Flush (flush_i=1, rst=0):
  - Next cycle: count=0, pointers=0, overflow_o=0, drop_cnt_o=0.
  - A push in the flush cycle is discarded and not counted as a drop. It still counts in commit_cnt_o.
  - The sequence counter is not reset.
  - A pop in the flush cycle is ignored; flush wins.
- Pointers use log2(DEPTH) bits plus a separate count register of log2(DEPTH)+1 bits. Full is count==DEPTH.

Optional Feature:
- Macro: COMMIT_TRACE_CHECKSUM_EN.
- Defined:
  - Adds output port checksum_o (32 bits).
  - Reset and flush set it to 0.
  - On each accepted push with post-filter wreg=1: checksum_o <= {checksum_o[30:0],checksum_o[31]} ^ commit_wdata_i ^ {27'b0,commit_waddr_i}.
  - Dropped, flushed and wreg=0 commits do not change it.
  - Updates one cycle after the push.
- Undefined:
  - Port absent; no checksum logic.
  - All other behaviour identical.

Test Plan:
- Single commit into empty FIFO (pc=0x1C000000, instr=0x02800C0C, wreg=1, waddr=12, wdata=3), trace_ready_i=1 -> trace_valid_o=1 exactly one cycle later with identical fields and seq=0; empty the following cycle; commit_cnt_o=1.
- DEPTH=16, 20 back-to-back commits with trace_ready_i=0 -> entries seq 0..15 retained; drop_cnt_o=4; overflow_o=1; almost_full_o=1 from the cycle count reaches 12; draining yields seq 0..15 in order; next accepted commit gets seq=16.
- FIFO full, commit_valid_i=1 and trace_ready_i=1 in the same cycle -> no drop; count stays 16; head advances by one; new entry appended.
- Commit with wreg=1, waddr=0, wdata=0xDEADBEEF -> trace_wreg_o=0, trace_wdata_o=0xDEADBEEF; checksum unchanged when COMMIT_TRACE_CHECKSUM_EN is defined.
- 5 entries buffered plus overflow set, then flush_i=1 together with commit_valid_i=1 -> next cycle trace_valid_o=0, overflow_o=0, drop_cnt_o=0; commit_cnt_o incremented; next accepted commit's seq continues from before the flush.
- rst=1 asserted mid-drain with 7 entries queued -> next cycle all outputs at reset values; the first commit after reset has seq=0.
